// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl
// Command stage in front of the servo PWM generator. Takes an angle command
// over valid/ready, turns it into a target pulse width with a sequential
// shift-add multiply, and slews on_period toward that target by at most
// STEP clocks once per frame. on_period only moves on the frame wrap, so the
// generator never sees a width change in the middle of a frame.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cmd_valid     command present
//   cmd_angle     commanded angle code, unsigned, ANGLE_W bits
//   cmd_ready     block can accept a command (IDLE and not in reset)
//   total_dur     generator period minus one, constant FRAME_TICKS-1
//   on_period     current slewed pulse width, in clocks
//   frame_start   one-cycle pulse on the first cycle of each frame
//   settled       registered on_period == target
module servo_slew_ctrl #(
  parameter int FRAME_TICKS = 1000000,
  parameter int MIN_PULSE   = 50000,
  parameter int MAX_PULSE   = 100000,
  parameter int STEP        = 500,
  parameter int ANGLE_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [ANGLE_W-1:0] cmd_angle,
  output logic               cmd_ready,
  output logic [31:0]        total_dur,
  output logic [31:0]        on_period,
  output logic               frame_start,
  output logic               settled
);

  localparam int          AW      = 32 + ANGLE_W;
  localparam int          CW      = $clog2(ANGLE_W + 1);
  localparam logic [31:0] SPAN    = 32'(MAX_PULSE - MIN_PULSE);
  localparam logic [31:0] MIN32   = 32'(MIN_PULSE);
  localparam logic [31:0] MID     = MIN32 + (SPAN >> 1);
  localparam logic [31:0] LAST    = 32'(FRAME_TICKS - 1);
  localparam logic [31:0] STEP32  = 32'(STEP);
  localparam logic [CW-1:0] LAST_IT = CW'(ANGLE_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, LOAD} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      it;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      mcand;
  logic [ANGLE_W-1:0] mplier;
  logic [31:0]        target;
  logic [31:0]        frame_cnt;
  logic               wrap;
  logic               accept;
  logic [31:0]        up_d, dn_d;

  assign total_dur = LAST;
  assign wrap      = (frame_cnt == LAST);
  assign accept    = (state == IDLE) && cmd_valid && !rst;
  assign up_d      = target - on_period;
  assign dn_d      = on_period - target;

  // The low ANGLE_W product bits are the fraction discarded by the >> ANGLE_W.
  logic unused_acc_lsb;
  assign unused_acc_lsb = ^acc[ANGLE_W-1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so ready stays low while reset is held.
        cmd_ready = !rst;
        if (cmd_valid && !rst) state_nx = CALC;
      end
      CALC:    if (it == LAST_IT) state_nx = LOAD;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ------------------------------------------------- shift-add multiply
  // LSB first: the multiplicand shifts left each iteration and is added
  // whenever the current multiplier bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      it     <= '0;
      target <= MID;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc    <= '0;
          mcand  <= AW'(SPAN);
          mplier <= cmd_angle;
          it     <= '0;
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          it     <= it + 1'b1;
        end
        LOAD:    target <= MIN32 + acc[ANGLE_W +: 32];
        default: ;
      endcase
    end
  end

  // ------------------------------------------------ frame counter / slew
  // frame_start is the registered wrap, so it is high exactly while the
  // counter sits at 0 after a wrap, but not in the first cycle after reset.
  // The slew uses the target as registered before this edge; a target loaded
  // on the same edge is picked up at the following wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      on_period   <= MID;
      frame_start <= 1'b0;
      settled     <= 1'b1;
    end else begin
      frame_start <= wrap;
      settled     <= (on_period == target);
      if (wrap) begin
        frame_cnt <= '0;
        if (on_period < target)
          on_period <= on_period + ((up_d < STEP32) ? up_d : STEP32);
        else if (on_period > target)
          on_period <= on_period - ((dn_d < STEP32) ? dn_d : STEP32);
      end else begin
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed bench for servo_slew_ctrl. Main DUT uses a 64-clock frame; a
// second instance with default parameters covers the full-size reset values.
module tb_servo_slew_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_angle;
  logic        cmd_ready;
  logic [31:0] total_dur;
  logic [31:0] on_period;
  logic        frame_start;
  logic        settled;

  logic        cmd_ready_d;
  logic [31:0] total_dur_d;
  logic [31:0] on_period_d;
  logic        frame_start_d;
  logic        settled_d;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  servo_slew_ctrl #(.FRAME_TICKS(64)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_angle(cmd_angle),
    .cmd_ready(cmd_ready), .total_dur(total_dur), .on_period(on_period),
    .frame_start(frame_start), .settled(settled)
  );

  servo_slew_ctrl dut_def (
    .clk(clk), .rst(rst), .cmd_valid(1'b0), .cmd_angle(8'd0),
    .cmd_ready(cmd_ready_d), .total_dur(total_dur_d), .on_period(on_period_d),
    .frame_start(frame_start_d), .settled(settled_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command in the current cycle, then count the ready-low cycles.
  task automatic send_cmd(input logic [7:0] a, output int low);
    chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_angle = a;
    step();
    cmd_valid = 1'b0;
    low = 0;
    while (!cmd_ready && low < 50) begin
      low++;
      step();
    end
  endtask

  // Advance to the next frame_start cycle; returns cycles taken.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 200);
    chk("frame_seen", {31'd0, frame_start}, 32'd1);
  endtask

  initial begin
    int low, n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_angle = 8'd0;

    // ---- reset values
    repeat (3) step();
    chk("rst_on_period",   on_period,   32'd75000);
    chk("rst_total_dur",   total_dur,   32'd63);
    chk("rst_ready",       {31'd0, cmd_ready},   32'd0);
    chk("rst_settled",     {31'd0, settled},     32'd1);
    chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
    chk("def_total_dur",   total_dur_d, 32'd999999);
    chk("def_on_period",   on_period_d, 32'd75000);
    chk("def_ready_rst",   {31'd0, cmd_ready_d}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, cmd_ready},   32'd1);
    chk("def_ready_after", {31'd0, cmd_ready_d}, 32'd1);
    chk("fs_first_cycle",  {31'd0, frame_start}, 32'd0);

    // ---- angle 0: 50 full steps down to 50000
    send_cmd(8'd0, low);
    chk("a0_ready_low", low, 32'd9);
    for (int k = 1; k <= 50; k++) begin
      wait_frame(n);
      chk("a0_on_period", on_period, 32'(75000 - 500 * k));
      chk("a0_settled_lo", {31'd0, settled}, 32'd0);
    end
    chk("a0_period", n, 32'd64);
    step();
    chk("a0_settled", {31'd0, settled}, 32'd1);
    wait_frame(n);
    chk("a0_hold", on_period, 32'd50000);

    // ---- angle 129 from reset: single partial step to 75195
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    send_cmd(8'd129, low);
    chk("a129_ready_low", low, 32'd9);
    wait_frame(n);
    chk("a129_on_period", on_period, 32'd75195);
    chk("a129_settled_lo", {31'd0, settled}, 32'd0);
    step();
    chk("a129_settled", {31'd0, settled}, 32'd1);
    wait_frame(n);
    chk("a129_no_overshoot", on_period, 32'd75195);

    // ---- angle 255 then reversal with angle 128
    send_cmd(8'd255, low);
    wait_frame(n);
    chk("a255_step1", on_period, 32'd75695);
    wait_frame(n);
    chk("a255_step2", on_period, 32'd76195);
    send_cmd(8'd128, low);
    wait_frame(n);
    chk("rev_step1", on_period, 32'd75695);
    wait_frame(n);
    chk("rev_step2", on_period, 32'd75195);
    wait_frame(n);
    chk("rev_final", on_period, 32'd75000);
    step();
    chk("rev_settled", {31'd0, settled}, 32'd1);

    // ---- target load on the same edge as the wrap (accept at count 54)
    repeat (53) step();
    send_cmd(8'd255, low);
    chk("same_fs", {31'd0, frame_start}, 32'd1);
    chk("same_old_target", on_period, 32'd75000);
    wait_frame(n);
    chk("same_new_target", on_period, 32'd75500);

    // ---- reset during CALC
    cmd_valid = 1'b1;
    cmd_angle = 8'd0;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    chk("calc_ready_lo", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b1;
    step();
    chk("calc_rst_on",  on_period, 32'd75000);
    chk("calc_rst_rdy", {31'd0, cmd_ready},   32'd0);
    chk("calc_rst_fs",  {31'd0, frame_start}, 32'd0);
    chk("calc_rst_set", {31'd0, settled},     32'd1);
    rst = 1'b0;
    #1;
    chk("calc_rdy_after", {31'd0, cmd_ready}, 32'd1);
    wait_frame(n);
    chk("calc_period", n, 32'd64);
    chk("calc_no_partial", on_period, 32'd75000);
    chk("calc_settled", {31'd0, settled}, 32'd1);

    // ---- reset mid-slew
    send_cmd(8'd0, low);
    wait_frame(n);
    chk("slew_pre_rst", on_period, 32'd74500);
    repeat (20) step();
    rst = 1'b1;
    step();
    chk("slew_rst_on",  on_period, 32'd75000);
    chk("slew_rst_set", {31'd0, settled},     32'd1);
    chk("slew_rst_fs",  {31'd0, frame_start}, 32'd0);
    rst = 1'b0;
    #1;
    wait_frame(n);
    chk("slew_period1", n, 32'd64);
    chk("slew_hold1", on_period, 32'd75000);
    wait_frame(n);
    chk("slew_period2", n, 32'd64);
    chk("slew_hold2", on_period, 32'd75000);
    chk("def_no_frame", {31'd0, frame_start_d}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/servo_slew_ctrl.md
# servo_slew_ctrl

Upstream command stage for the servo PWM generator. Accepts angle commands over a valid/ready handshake, converts each to a target pulse width with a sequential shift-add multiplier, and slews the pulse width toward that target by a bounded step once per PWM frame. Drives the generator's `total_dur` and `on_period` inputs, and changes `on_period` only on frame boundaries so the generator never sees a width change mid-frame.

## Interface
- `FRAME_TICKS`, default 1000000: frame length in clocks (20 ms at 50 MHz).
- `MIN_PULSE`, default 50000: pulse width for angle 0, in clocks.
- `MAX_PULSE`, default 100000: full-scale pulse width; `SPAN = MAX_PULSE - MIN_PULSE`.
- `STEP`, default 500: maximum `on_period` change per frame, in clocks.
- `ANGLE_W`, default 8: command angle width.
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_angle`  in  ANGLE_W: commanded angle code, unsigned.
- `cmd_ready`  out  1: block can accept a command.
- `total_dur`  out  32: to generator; constant `FRAME_TICKS-1`.
- `on_period`  out  32: to generator; current slewed pulse width.
- `frame_start`  out  1: one-cycle pulse on the first cycle of each frame.
- `settled`  out  1: high when `on_period == target`.

## Operation
- Reset values: `on_period = target = MIN_PULSE + SPAN/2`; frame counter = 0; FSM in IDLE; `cmd_ready = 0` during reset and 1 on the first cycle after it; `frame_start = 0`; `settled = 1`; `total_dur = FRAME_TICKS-1` at all times.
- FSM states:
  - IDLE: `cmd_ready = 1`. `cmd_valid & cmd_ready` latches `cmd_angle`, clears the accumulator, and moves to CALC.
  - CALC: `cmd_ready = 0`. Runs `ANGLE_W` shift-add iterations, LSB first, computing `SPAN * angle` into a 32+ANGLE_W bit accumulator. On the last iteration it moves to LOAD.
  - LOAD: `target <= MIN_PULSE + ((SPAN*angle) >> ANGLE_W)`, then returns to IDLE. The result truncates: angle 255 gives `MIN_PULSE + floor(SPAN*255/256)`.
- Frame counter: counts 0..`FRAME_TICKS-1` and wraps to 0. This is lockstep with the generator, whose period is `total_dur+1` clocks from a common reset.
- Slew: on the clock edge where the counter wraps to 0:
  - if `on_period < target`, `on_period += min(STEP, target - on_period)`;
  - if `on_period > target`, `on_period -= min(STEP, on_period - target)`;
  - otherwise no change.
  - Arithmetic is 32-bit unsigned. Overshoot is impossible by construction.
- Commands are accepted while slewing is in progress. A new target replaces the old one, and slewing continues from the current `on_period`.
- `cmd_valid` held high with a constant angle: accepted once per IDLE visit. Re-acceptance of the same value is harmless.

## Timing
- Acceptance cycle T (IDLE, handshake true) → CALC during cycles T+1..T+ANGLE_W → LOAD at T+ANGLE_W+1, when `target` is written → `cmd_ready` high again at T+ANGLE_W+2.
- A target written in the same cycle as a frame wrap is not used by that wrap, which slews toward the old registered target. The new target takes effect at the next wrap.
- `on_period` is registered and changes only on the edge into counter value 0. `frame_start` is high exactly in the cycle where the counter = 0, except the first cycle after reset.
- `settled` is registered and reflects `on_period == target` one cycle after either register changes.
- `rst` asserted mid-CALC or mid-slew: on the next edge, all state returns to reset values; no partial target is written.

## Test plan
- Reset: hold `rst` 3 cycles → `on_period = 75000`, `total_dur = 999999`, `cmd_ready = 0` during reset and 1 the cycle after, `settled = 1`, `frame_start = 0`.
- Command angle 0: `cmd_ready` low for exactly 9 cycles; target 50000 → `on_period` steps 74500, 74000, … one step per `frame_start`, reaching 50000 after 50 frames, then `settled = 1`.
- Command angle 129 from reset → target 75195 → `on_period = 75195` after a single frame wrap, with the remainder step < STEP; verify no overshoot.
- Command angle 255 → target 99804; then mid-slew send angle 128 → target 75000; verify direction reverses at the next wrap from the current value.
- Target write in the same cycle as a wrap (use a small FRAME_TICKS build, e.g. 64) → that wrap uses the old target; the new one applies one frame later.
- Assert `rst` during CALC and again mid-slew → outputs at reset values next cycle; generator period remains 64/1000000 clocks, aligned with `frame_start`.
